// File: rtl/mem_stream_reader_pkg.sv
// Shared state encoding and elaboration helpers for mem_stream_reader.
package mem_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_stream_reader_stream_fifo.sv
// stream_fifo: synchronous power-of-two FIFO used as the output buffer of mem_stream_reader.
module stream_fifo
  import mem_stream_reader_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [log2_ceil(DEPTH):0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = log2_ceil(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // Storage is left unreset; the consumer gates the head word with empty.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign pop_data = storage[rd_ptr];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: strided read sequencer feeding a valid/ready stream from a 1-cycle-latency memory.
// Optional ring-buffer address wrap is enabled by defining MEM_STREAM_READER_WRAP_EN.
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_SIZE  = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH-1:0] STRIDE,
  input  logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_RE,
  output logic                  MEM_WE,
  output logic [DATA_WIDTH-1:0] MEM_D,
  input  logic [DATA_WIDTH-1:0] MEM_Q,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST
);

  localparam int CW = log2_ceil(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_CREDIT = (CW + 1)'(FIFO_DEPTH);

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
    $error("mem_stream_reader: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!is_pow2(WRAP_SIZE)) begin : g_bad_wrap
    $error("mem_stream_reader: WRAP_SIZE must be a power of two");
  end

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] advanced_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  accept;
  logic                  issue;
  logic                  last_issue;
  logic                  pop;
  logic [CW:0]           occupancy;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   head;

  assign accept = (state == ST_IDLE) && START;

  // A pop this cycle frees the slot the word issued now will land in, which keeps a depth-2 FIFO at full rate.
  always_comb begin
    occupancy  = (CW + 1)'(fifo_count) + (CW + 1)'(inflight) - (CW + 1)'(pop);
    issue      = (state == ST_ISSUE) && (remaining != '0) && !fifo_full &&
                 (occupancy < DEPTH_CREDIT);
    last_issue = issue && (remaining == CNT_WIDTH'(1));
  end

`ifdef MEM_STREAM_READER_WRAP_EN
  localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'(WRAP_SIZE - 1);
  logic [ADDR_WIDTH-1:0] base_aligned;

  always_ff @(posedge CLK) begin
    if (RST)         base_aligned <= '0;
    else if (accept) base_aligned <= BASE_ADDR & ~WRAP_MASK;
  end

  assign advanced_addr = base_aligned | ((next_addr - base_aligned + stride_q) & WRAP_MASK);
`else
  assign advanced_addr = next_addr + stride_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Run bookkeeping; a reset also drops the read in flight so its data never reaches the FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      next_addr     <= '0;
      stride_q      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (accept) begin
        next_addr <= BASE_ADDR;
        stride_q  <= STRIDE;
        remaining <= COUNT;
      end else if (issue) begin
        next_addr <= advanced_addr;
        remaining <= remaining - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    BUSY       = 1'b1;
    DONE       = 1'b0;
    MEM_RE     = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) next_state = (COUNT == '0) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE: begin
        MEM_RE = issue;
        if (last_issue) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && head[DATA_WIDTH]) next_state = ST_FINISH;
      end
      ST_FINISH: begin
        DONE       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  stream_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (inflight),
    .push_data({inflight_last, MEM_Q}),
    .pop      (pop),
    .pop_data (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_VALID = !fifo_empty;
  assign OUT_DATA  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign OUT_LAST  = !fifo_empty && head[DATA_WIDTH];
  assign MEM_ADDR  = next_addr;
  assign MEM_WE    = 1'b0;
  assign MEM_D     = '0;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a 1-cycle-latency memory model.
module tb_mem_stream_reader;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int CNTW  = 16;
  localparam int DEPTH = 4;
  localparam int WRAP  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   stride;
  logic [CNTW-1:0] count;
  logic            busy, done;
  logic [AW-1:0]   mem_addr;
  logic            mem_re, mem_we;
  logic [DW-1:0]   mem_d;
  logic [DW-1:0]   mem_q = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last;

  int compared   = 0;
  int mismatched = 0;

  mem_stream_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CNTW),
    .FIFO_DEPTH(DEPTH), .WRAP_SIZE(WRAP)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .BASE_ADDR(base_addr), .STRIDE(stride),
    .COUNT(count), .BUSY(busy), .DONE(done), .MEM_ADDR(mem_addr), .MEM_RE(mem_re),
    .MEM_WE(mem_we), .MEM_D(mem_d), .MEM_Q(mem_q), .OUT_DATA(out_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_LAST(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return {16'hC0DE, a ^ 16'h5A5A};
  endfunction

  // Memory returns the addressed word one cycle after a read enable.
  always @(posedge clk) begin
    if (mem_re) mem_q <= memWord(mem_addr);
  end

  int neg_count = 0;
  int start_neg = 0;
  logic [AW-1:0] addr_q[$];
  int            addr_cyc[$];
  logic [DW:0]   out_q[$];
  int            out_cyc[$];
  int done_cnt, done_cyc, busy_cnt, busy_first, busy_last, valid_cnt, issued, popped, max_out;
  logic [AW-1:0] exp_addr[$];

  always @(negedge clk) begin
    int rel;
    neg_count++;
    rel = neg_count - start_neg;
    if (mem_re) begin
      addr_q.push_back(mem_addr);
      addr_cyc.push_back(rel);
      issued++;
    end
    if (out_valid) valid_cnt++;
    if (out_valid && out_ready) begin
      out_q.push_back({out_last, out_data});
      out_cyc.push_back(rel);
      popped++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = rel;
    end
    if (busy) begin
      if (busy_cnt == 0) busy_first = rel;
      busy_last = rel;
      busy_cnt++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    addr_q.delete(); addr_cyc.delete(); out_q.delete(); out_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    valid_cnt = 0; issued = 0; popped = 0; max_out = 0;
  endtask

  // Drives a one-cycle START; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CNTW-1:0] n);
    clearLogs();
    start = 1'b1; base_addr = b; stride = s; count = n;
    waitCycles(1);
    start_neg = neg_count;
    start = 1'b0;
  endtask

  task automatic fillExpected(input logic [AW-1:0] b, input logic [AW-1:0] s, input int n);
    logic [AW-1:0] a;
    logic [AW-1:0] aligned;
    exp_addr.delete();
    a = b;
    aligned = b & ~AW'(WRAP - 1);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(a);
`ifdef MEM_STREAM_READER_WRAP_EN
      a = aligned | ((a - aligned + s) & AW'(WRAP - 1));
`else
      a = a + s;
`endif
    end
  endtask

  task automatic checkStream(input string tag);
    int n;
    n = exp_addr.size();
    checkOutput($sformatf("%s re_count", tag), 64'(addr_q.size()), 64'(n));
    checkOutput($sformatf("%s out_count", tag), 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i),
                  (i < addr_q.size()) ? 64'(addr_q[i]) : 64'hDEAD_0000_0000_0000, 64'(exp_addr[i]));
      checkOutput($sformatf("%s word[%0d]", tag, i),
                  (i < out_q.size()) ? 64'(out_q[i]) : 64'hDEAD_0000_0000_0000,
                  64'({(i == n - 1), memWord(exp_addr[i])}));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " flags"}, 64'({busy, done, mem_re, mem_we, out_valid, out_last}), 64'd0);
    checkOutput({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({tag, " mem_d"}, 64'(mem_d), 64'd0);
    checkOutput({tag, " out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    int win;
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; out_ready = 1'b1;
    clearLogs();
    waitCycles(2);
    @(negedge clk);
    checkAllZero("reset");
    waitCycles(1);
    rst = 1'b0;
    waitCycles(1);

    $display("[TB] run 1: base 0x100 stride 4 count 8, ready high");
    fillExpected(16'h0100, 16'd4, 8);
    applyStimulus(16'h0100, 16'd4, 16'd8);
    waitCycles(13);
    checkStream("run1");
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("run1 re_cycle[%0d]", i), 64'(addr_cyc[i]), 64'(i + 1));
      checkOutput($sformatf("run1 out_cycle[%0d]", i), 64'(out_cyc[i]), 64'(i + 3));
    end
    checkOutput("run1 done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("run1 done_cyc", 64'(done_cyc), 64'd11);
    checkOutput("run1 busy_first", 64'(busy_first), 64'd1);
    checkOutput("run1 busy_last", 64'(busy_last), 64'd11);
    checkOutput("run1 busy_cnt", 64'(busy_cnt), 64'd11);

    $display("[TB] run 2: backpressure for 10 cycles after the first word");
    fillExpected(16'h0100, 16'd4, 8);
    applyStimulus(16'h0100, 16'd4, 16'd8);
    waitCycles(3);
    out_ready = 1'b0;
    waitCycles(10);
    out_ready = 1'b1;
    waitCycles(12);
    checkStream("run2");
    win = 0;
    foreach (addr_cyc[i]) if (addr_cyc[i] >= 7 && addr_cyc[i] <= 13) win++;
    checkOutput("run2 re_while_full", 64'(win), 64'd0);
    checkOutput("run2 max_buffered", 64'(max_out), 64'(DEPTH));
    checkOutput("run2 done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("run2 done_cyc", 64'(done_cyc), 64'd21);

    $display("[TB] run 3: count 0");
    applyStimulus(16'h0040, 16'd4, 16'd0);
    waitCycles(6);
    checkOutput("cnt0 re_count", 64'(addr_q.size()), 64'd0);
    checkOutput("cnt0 valid_cnt", 64'(valid_cnt), 64'd0);
    checkOutput("cnt0 done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("cnt0 done_cyc", 64'(done_cyc), 64'd1);
    checkOutput("cnt0 busy_cnt", 64'(busy_cnt), 64'd1);

    $display("[TB] run 4: address wrap at the top of the address space");
`ifdef MEM_STREAM_READER_WRAP_EN
    exp_addr = '{16'hFFF8, 16'hFFFC, 16'hFFF0, 16'hFFF4};
`else
    exp_addr = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
`endif
    applyStimulus(16'hFFF8, 16'd4, 16'd4);
    waitCycles(10);
    checkStream("top_wrap");
    checkOutput("top_wrap done_cnt", 64'(done_cnt), 64'd1);

`ifdef MEM_STREAM_READER_WRAP_EN
    exp_addr = '{16'h1008, 16'h100C, 16'h1000, 16'h1004, 16'h1008, 16'h100C};
`else
    exp_addr = '{16'h1008, 16'h100C, 16'h1010, 16'h1014, 16'h1018, 16'h101C};
`endif
    applyStimulus(16'h1008, 16'd4, 16'd6);
    waitCycles(12);
    checkStream("window");
    checkOutput("window done_cyc", 64'(done_cyc), 64'd9);

    $display("[TB] run 5: reset mid-run with data buffered");
    out_ready = 1'b0;
    applyStimulus(16'h0500, 16'd4, 16'd8);
    waitCycles(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("prereset out_valid", 64'(out_valid), 64'd1);
    waitCycles(1);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("midrun_reset");
    waitCycles(3);
    checkOutput("midrun_reset valid_cnt", 64'(valid_cnt), 64'd2);
    checkOutput("midrun_reset re_count", 64'(addr_q.size()), 64'd4);
    checkOutput("midrun_reset done_cnt", 64'(done_cnt), 64'd0);
    checkOutput("midrun_reset busy_last", 64'(busy_last), 64'd4);
    out_ready = 1'b1;
    fillExpected(16'h0200, 16'd8, 3);
    applyStimulus(16'h0200, 16'd8, 16'd3);
    waitCycles(8);
    checkStream("after_reset");
    checkOutput("after_reset done_cyc", 64'(done_cyc), 64'd6);

    $display("[TB] run 6: START while busy is ignored");
    fillExpected(16'h0300, 16'd4, 4);
    applyStimulus(16'h0300, 16'd4, 16'd4);
    waitCycles(1);
    start = 1'b1; base_addr = 16'h0900; stride = 16'h0010; count = 16'd2;
    waitCycles(1);
    start = 1'b0;
    waitCycles(10);
    checkStream("busy_start");
    checkOutput("busy_start done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("busy_start done_cyc", 64'(done_cyc), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
